// File: rtl/regfile_pkg.sv
// Shared sizing and the one-hot helper for the register-file write controller.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2**ADDR_W;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = 2**CNT_W - 1;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational address-to-one-hot decoder; addresses at or above NUM_REGS,
// or a low enable, give an all-zero vector.
module onehot_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] dec
);

    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                dec[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: registered one-hot write enable, per-register
// saturating pending counters and read-port hazard flags. WB_BYPASS_EN masks a hazard
// in the cycle its last pending write retires.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int CNT_W    = regfile_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Issue_Valid_i,
    input  logic [ADDR_W-1:0]   Issue_Reg_i,
    output logic                Issue_Ready_o,
    input  logic                WB_Valid_i,
    input  logic [ADDR_W-1:0]   WB_Reg_i,
    input  logic [ADDR_W-1:0]   Read_Reg_A_i,
    input  logic [ADDR_W-1:0]   Read_Reg_B_i,
    output logic                Hazard_A_o,
    output logic                Hazard_B_o,
    output logic [NUM_REGS-1:0] Write_Enable_o,
    output logic [NUM_REGS-1:0] Pending_o,
    output logic                Err_Underflow_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] underflow;
    logic [NUM_REGS-1:0] retire;
    logic [NUM_REGS-1:0] we_d;
    logic [NUM_REGS-1:0] we_q;
    logic [CNT_W-1:0]    issue_cnt;
    logic                wb_same;
    logic                issue_acc;
    logic                err_q;
    logic                dec_en;

    // Counter 0 never leaves zero, so register 0 always reads as ready and hazard-free.
    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Issue_Reg_i == ADDR_W'(i)) begin
                issue_cnt = cnt_q[i];
            end
        end
        wb_same       = WB_Valid_i && (WB_Reg_i == Issue_Reg_i);
        Issue_Ready_o = !((issue_cnt == CNT_FULL) && !wb_same);
        issue_acc     = Issue_Valid_i && Issue_Ready_o;
    end

    always_comb begin
        logic inc;
        logic dec;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i]     = cnt_q[i];
            underflow[i] = 1'b0;
            retire[i]    = 1'b0;
            pending[i]   = (cnt_q[i] != '0);
            inc          = 1'b0;
            dec          = 1'b0;
            if (i != 0) begin
                inc = issue_acc && (Issue_Reg_i == ADDR_W'(i));
                dec = WB_Valid_i && (WB_Reg_i == ADDR_W'(i));
            end
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) begin
                    underflow[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
`ifdef WB_BYPASS_EN
            retire[i] = dec && !inc && (cnt_q[i] == CNT_W'(1));
`endif
        end
    end

    always_comb begin
        Hazard_A_o = 1'b0;
        Hazard_B_o = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Read_Reg_A_i == ADDR_W'(i)) begin
                Hazard_A_o = pending[i] && !retire[i];
            end
            if (Read_Reg_B_i == ADDR_W'(i)) begin
                Hazard_B_o = pending[i] && !retire[i];
            end
        end
    end

    assign dec_en = WB_Valid_i && (WB_Reg_i != '0);

    onehot_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_we_dec (
        .en   (dec_en),
        .addr (WB_Reg_i),
        .dec  (we_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            we_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            we_q <= we_d;
            if (|underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Pending_o       = pending;
    assign Write_Enable_o  = we_q;
    assign Err_Underflow_o = err_q;

endmodule
